spim_reg_mc: RTL and testbench

Multi-channel, parametrised register bank for the SPI master. It replaces the single-channel register block.
- Provides NUM_CH independent channel register windows, each with: command, status, diagnostics, read-back and buffer control/status registers.
- Adds a registered read path with a real data-valid pulse, write-1-to-clear sticky error capture from event pulses, and self-timed soft-reset pulses.
- Sits between the AVMM slave decode and the per-channel SPI master transaction engines.

---
 rtl/spim_reg_pkg.sv | 28 ++
 rtl/spim_reg_ch.sv | 108 ++++++++++
 rtl/spim_reg_mc.sv | 90 +++++++++
 tb/tb_spim_reg_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spim_reg_pkg.sv
// Shared register map, event bit positions and soft-reset mode encoding
// for the multi-channel SPI master register bank.
package spim_reg_pkg;

  localparam logic [15:0] OFF_CMD        = 16'h0000;
  localparam logic [15:0] OFF_STATUS     = 16'h000C;
  localparam logic [15:0] OFF_DIAG0      = 16'h0010;
  localparam logic [15:0] OFF_DIAG1      = 16'h0014;
  localparam logic [15:0] OFF_RDBACK     = 16'h0020;
  localparam logic [15:0] OFF_STICKY     = 16'h0040;
  localparam logic [15:0] OFF_IRQ_MASK   = 16'h0044;
  localparam logic [15:0] OFF_SFRST_CTRL = 16'h0048;
  localparam logic [15:0] OFF_SFRST_STS  = 16'h004C;

  // buf_evt / STICKY bit positions
  localparam int EVT_WBUF_WR_OVF = 0;
  localparam int EVT_WBUF_RD_UDF = 1;
  localparam int EVT_RBUF_WR_OVF = 2;
  localparam int EVT_RBUF_RD_UDF = 3;

  localparam int SFRST_MODE_BIT = 8;

  typedef enum logic {
    SFRST_PULSE = 1'b0,
    SFRST_LEVEL = 1'b1
  } sfrst_mode_e;

endpackage

// File: rtl/spim_reg_ch.sv
// One channel register window: command, sampled status/diag, sticky
// errors with irq, and the self-timed buffer soft-reset generator.
module spim_reg_ch
  import spim_reg_pkg::*;
#(
  parameter int SFRST_CYC = 4
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic        wr_en,
  input  logic [15:0] off,
  input  logic [31:0] wdata,
  input  logic        trans_done,
  input  logic [31:0] status_in,
  input  logic [31:0] diag0_in,
  input  logic        load_diag0,
  input  logic [31:0] diag1_in,
  input  logic [31:0] rb_in,
  input  logic [3:0]  evt,
  output logic [31:0] cmd,
  output logic [3:0]  sfrst,
  output logic        irq,
  output logic [31:0] rd_data,
  output logic        rd_hit
);

  localparam logic [3:0] SFRST_LOAD = 4'(SFRST_CYC);

  logic [31:0] status_q, diag0_q, diag1_q, rb_q;
  logic [3:0]  sticky, mask;
  logic [3:0]  sfrst_req, sfrst_act, sfrst_cnt;
  sfrst_mode_e sfrst_mode, wr_mode;
  logic        wr_cmd, wr_sticky, wr_mask, wr_sfrst;

  assign wr_cmd    = wr_en && (off == OFF_CMD);
  assign wr_sticky = wr_en && (off == OFF_STICKY);
  assign wr_mask   = wr_en && (off == OFF_IRQ_MASK);
  assign wr_sfrst  = wr_en && (off == OFF_SFRST_CTRL);
  assign wr_mode   = sfrst_mode_e'(wdata[SFRST_MODE_BIT]);

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      status_q   <= '0;
      diag0_q    <= '0;
      diag1_q    <= '0;
      rb_q       <= '0;
      cmd        <= '0;
      sticky     <= '0;
      mask       <= '0;
      irq        <= 1'b0;
      sfrst_mode <= SFRST_PULSE;
      sfrst_req  <= '0;
      sfrst_act  <= '0;
      sfrst_cnt  <= '0;
    end else begin
      status_q <= status_in;
      diag1_q  <= diag1_in;
      rb_q     <= rb_in;
      if (load_diag0) diag0_q <= diag0_in;

      // GO is write-protected while set; the engine's accept wins over a write
      if (wr_cmd) cmd <= cmd[0] ? {wdata[31:1], 1'b1} : wdata;
      if (trans_done) cmd[0] <= 1'b0;

      sticky <= (sticky & ~(wr_sticky ? wdata[3:0] : 4'h0)) | evt;
      if (wr_mask) mask <= wdata[3:0];
      irq <= |(sticky & mask);

      if (wr_sfrst && (wr_mode != sfrst_mode)) begin
        sfrst_mode <= wr_mode;
        sfrst_req  <= wdata[3:0];
        sfrst_cnt  <= '0;
        sfrst_act  <= '0;
      end else if (wr_sfrst && (sfrst_mode == SFRST_PULSE) && (|wdata[3:0])) begin
        sfrst_req  <= wdata[3:0];
        sfrst_act  <= sfrst_act | wdata[3:0];
        sfrst_cnt  <= SFRST_LOAD;
      end else begin
        if (wr_sfrst) sfrst_req <= wdata[3:0];
        if (sfrst_cnt != 4'd0) begin
          sfrst_cnt <= sfrst_cnt - 4'd1;
          if (sfrst_cnt == 4'd1) sfrst_act <= '0;
        end
      end
    end
  end

  // active set is already empty whenever the counter is idle
  assign sfrst = (sfrst_mode == SFRST_LEVEL) ? sfrst_req : sfrst_act;

  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    case (off)
      OFF_CMD:        rd_data = cmd;
      OFF_STATUS:     rd_data = status_q;
      OFF_DIAG0:      rd_data = diag0_q;
      OFF_DIAG1:      rd_data = diag1_q;
      OFF_RDBACK:     rd_data = rb_q;
      OFF_STICKY:     rd_data = {28'h0, sticky};
      OFF_IRQ_MASK:   rd_data = {28'h0, mask};
      OFF_SFRST_CTRL: rd_data = {23'h0, sfrst_mode, 4'h0, sfrst_req};
      OFF_SFRST_STS:  rd_data = {24'h0, sfrst_cnt, 3'h0, (sfrst_cnt != 4'd0)};
      default:        rd_hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/spim_reg_mc.sv
// Multi-channel SPI master register bank: address decode into NUM_CH
// channel windows, read mux and registered read response.
module spim_reg_mc
  import spim_reg_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter logic [15:0] CH_STRIDE  = 16'h0100,
  parameter int          SFRST_CYC  = 4,
  parameter logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic [31:0]          wdata,
  input  logic                 write,
  input  logic                 read,
  input  logic [15:0]          addr,
  output logic [31:0]          rdata,
  output logic                 rdatavld,
  output logic                 rd_err,
  input  logic [NUM_CH-1:0]    stransvld_up,
  input  logic [32*NUM_CH-1:0] m_status_in,
  input  logic [32*NUM_CH-1:0] m_diag0_in,
  input  logic [NUM_CH-1:0]    load_dbg_bus0,
  input  logic [32*NUM_CH-1:0] m_diag1_in,
  input  logic [32*NUM_CH-1:0] avmm_rb_data,
  input  logic [4*NUM_CH-1:0]  buf_evt,
  output logic [32*NUM_CH-1:0] m_cmd,
  output logic [4*NUM_CH-1:0]  buf_sfrst,
  output logic [NUM_CH-1:0]    irq
);

  localparam int CH_SHIFT = $clog2(CH_STRIDE);

  logic [15:0]              ch_idx, off;
  logic [NUM_CH-1:0][31:0]  ch_rd;
  logic [NUM_CH-1:0]        ch_hit;
  logic [31:0]              sel_data;
  logic                     sel_hit;

  // stride is a power of two, so divide/modulo reduce to shift/mask
  assign ch_idx = addr >> CH_SHIFT;
  assign off    = addr & (CH_STRIDE - 16'd1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    spim_reg_ch #(.SFRST_CYC(SFRST_CYC)) u_ch (
      .aclk       (aclk),
      .arst_n     (arst_n),
      .wr_en      (write && (ch_idx == 16'(gi))),
      .off        (off),
      .wdata      (wdata),
      .trans_done (stransvld_up[gi]),
      .status_in  (m_status_in[gi*32 +: 32]),
      .diag0_in   (m_diag0_in[gi*32 +: 32]),
      .load_diag0 (load_dbg_bus0[gi]),
      .diag1_in   (m_diag1_in[gi*32 +: 32]),
      .rb_in      (avmm_rb_data[gi*32 +: 32]),
      .evt        (buf_evt[gi*4 +: 4]),
      .cmd        (m_cmd[gi*32 +: 32]),
      .sfrst      (buf_sfrst[gi*4 +: 4]),
      .irq        (irq[gi]),
      .rd_data    (ch_rd[gi]),
      .rd_hit     (ch_hit[gi])
    );
  end

  always_comb begin
    sel_hit  = 1'b0;
    sel_data = RD_DEFAULT;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((ch_idx == 16'(c)) && ch_hit[c]) begin
        sel_hit  = 1'b1;
        sel_data = ch_rd[c];
      end
    end
  end

  // register values are sampled before any same-cycle write lands
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      rdata    <= '0;
      rdatavld <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rdatavld <= read;
      rd_err   <= read && !sel_hit;
      if (read) rdata <= sel_data;
    end
  end

endmodule

// File: tb/tb_spim_reg_mc.sv
// Directed self-checking bench for spim_reg_mc (NUM_CH = 2, SFRST_CYC = 4).
module tb_spim_reg_mc;
  import spim_reg_pkg::*;

  localparam int NUM_CH = 2;

  logic                 aclk, arst_n;
  logic [31:0]          wdata;
  logic                 write, read;
  logic [15:0]          addr;
  logic [31:0]          rdata;
  logic                 rdatavld, rd_err;
  logic [NUM_CH-1:0]    stransvld_up;
  logic [32*NUM_CH-1:0] m_status_in, m_diag0_in, m_diag1_in, avmm_rb_data;
  logic [NUM_CH-1:0]    load_dbg_bus0;
  logic [4*NUM_CH-1:0]  buf_evt;
  logic [32*NUM_CH-1:0] m_cmd;
  logic [4*NUM_CH-1:0]  buf_sfrst;
  logic [NUM_CH-1:0]    irq;

  int checks = 0;
  int errors = 0;

  spim_reg_mc #(.NUM_CH(NUM_CH), .CH_STRIDE(16'h0100), .SFRST_CYC(4),
                .RD_DEFAULT(32'hDEAD_BEEF)) dut (
    .aclk(aclk), .arst_n(arst_n), .wdata(wdata), .write(write), .read(read),
    .addr(addr), .rdata(rdata), .rdatavld(rdatavld), .rd_err(rd_err),
    .stransvld_up(stransvld_up), .m_status_in(m_status_in),
    .m_diag0_in(m_diag0_in), .load_dbg_bus0(load_dbg_bus0),
    .m_diag1_in(m_diag1_in), .avmm_rb_data(avmm_rb_data), .buf_evt(buf_evt),
    .m_cmd(m_cmd), .buf_sfrst(buf_sfrst), .irq(irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge aclk); write = 1'b1; addr = a; wdata = d;
    @(negedge aclk); write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic v, output logic e);
    @(negedge aclk); read = 1'b1; addr = a;
    @(negedge aclk); read = 1'b0;
    d = rdata; v = rdatavld; e = rd_err;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v, e;
    arst_n = 1'b0; write = 0; read = 0; addr = 0; wdata = 0;
    stransvld_up = 0; load_dbg_bus0 = 0; buf_evt = 0;
    m_status_in = 0; m_diag0_in = 0; m_diag1_in = 0; avmm_rb_data = 0;
    repeat (3) @(negedge aclk);
    checks++; if ({rdatavld, rd_err, irq, buf_sfrst} !== 12'h0 || m_cmd !== 64'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: vld=%b err=%b irq=%b sfrst=%h cmd=%h rdata=%h expected all 0", rdatavld, rd_err, irq, buf_sfrst, m_cmd, rdata); end
    arst_n = 1'b1;
    rd(16'h0000, d, v, e);
    checks++; if ({v, e, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rd_ch0_cmd: vld=%b err=%b data=%h expected 1 0 00000000", v, e, d); end
    rd(16'h0140, d, v, e);
    checks++; if ({v, e, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rd_ch1_sticky: vld=%b err=%b data=%h expected 1 0 00000000", v, e, d); end
    rd(16'h0204, d, v, e);
    checks++; if ({v, e, d} !== {2'b11, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd_bad_ch: vld=%b err=%b data=%h expected 1 1 deadbeef", v, e, d); end
    rd(16'h0004, d, v, e);
    checks++; if ({v, e, d} !== {2'b11, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd_bad_off: vld=%b err=%b data=%h expected 1 1 deadbeef", v, e, d); end
    @(negedge aclk);
    checks++; if ({rdatavld, rd_err, rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL rd_pulse_hold: vld=%b err=%b data=%h expected 0 0 deadbeef", rdatavld, rd_err, rdata); end
  endtask

  task automatic test_cmd();
    logic [31:0] d; logic v, e;
    wr(16'h0100, 32'h8000_0005);
    checks++; if (m_cmd[63:32] !== 32'h8000_0005) begin errors++; $display("FAIL cmd_write: got %h expected 80000005", m_cmd[63:32]); end
    wr(16'h0100, 32'h0000_0000);
    checks++; if (m_cmd[63:32] !== 32'h0000_0001) begin errors++; $display("FAIL cmd_go_protect: got %h expected 00000001", m_cmd[63:32]); end
    wr(16'h0100, 32'h8000_0005);
    @(negedge aclk); stransvld_up = 2'b10;
    @(negedge aclk); stransvld_up = 2'b00;
    rd(16'h0100, d, v, e);
    checks++; if (d !== 32'h8000_0004) begin errors++; $display("FAIL cmd_go_clear: got %h expected 80000004", d); end
    wr(16'h0100, 32'h8000_0005);
    @(negedge aclk); write = 1'b1; addr = 16'h0100; wdata = 32'h0000_00F1; stransvld_up = 2'b10;
    @(negedge aclk); write = 1'b0; stransvld_up = 2'b00;
    rd(16'h0100, d, v, e);
    checks++; if (d !== 32'h0000_00F0) begin errors++; $display("FAIL cmd_clear_vs_write: got %h expected 000000f0", d); end
    checks++; if (m_cmd[31:0] !== 32'h0) begin errors++; $display("FAIL cmd_ch0_isolated: got %h expected 00000000", m_cmd[31:0]); end
  endtask

  task automatic test_status();
    logic [31:0] d; logic v, e;
    m_status_in  = {32'h1234_5678, 32'hCAFE_0001};
    m_diag0_in   = {32'h0, 32'hA5A5_0001};
    m_diag1_in   = {32'h0D1A_0001, 32'h0};
    avmm_rb_data = {32'h0, 32'hBEEF_0042};
    rd(16'h010C, d, v, e);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL status_ch1: got %h expected 12345678", d); end
    rd(16'h0010, d, v, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL diag0_no_load: got %h expected 00000000", d); end
    @(negedge aclk); load_dbg_bus0 = 2'b01;
    @(negedge aclk); load_dbg_bus0 = 2'b00; m_diag0_in[31:0] = 32'h1111_1111;
    rd(16'h0010, d, v, e);
    checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL diag0_capture: got %h expected a5a50001", d); end
    rd(16'h0114, d, v, e);
    checks++; if (d !== 32'h0D1A_0001) begin errors++; $display("FAIL diag1_ch1: got %h expected 0d1a0001", d); end
    rd(16'h0020, d, v, e);
    checks++; if (d !== 32'hBEEF_0042) begin errors++; $display("FAIL rdback_ch0: got %h expected beef0042", d); end
  endtask

  task automatic test_sticky();
    logic [31:0] d; logic v, e;
    wr(16'h0044, 32'h1);
    @(negedge aclk); buf_evt[EVT_WBUF_WR_OVF] = 1'b1;
    @(negedge aclk); buf_evt = '0;
    rd(16'h0040, d, v, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL sticky_set: got %h expected 00000001", d); end
    checks++; if (irq !== 2'b01) begin errors++; $display("FAIL irq_set: got %b expected 01", irq); end
    @(negedge aclk); write = 1'b1; addr = 16'h0040; wdata = 32'h1; buf_evt[EVT_WBUF_WR_OVF] = 1'b1;
    @(negedge aclk); write = 1'b0; buf_evt = '0;
    rd(16'h0040, d, v, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL sticky_set_wins: got %h expected 00000001", d); end
    wr(16'h0040, 32'h1);
    rd(16'h0040, d, v, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sticky_w1c: got %h expected 00000000", d); end
    checks++; if (irq !== 2'b00) begin errors++; $display("FAIL irq_drop: got %b expected 00", irq); end
    @(negedge aclk); buf_evt[4 + EVT_RBUF_RD_UDF] = 1'b1;
    @(negedge aclk); buf_evt = '0;
    rd(16'h0140, d, v, e);
    checks++; if (d !== 32'h8 || irq !== 2'b00) begin errors++; $display("FAIL sticky_ch1_masked: sticky=%h irq=%b expected 00000008 00", d, irq); end
    wr(16'h0144, 32'h8);
    @(negedge aclk);
    checks++; if (irq !== 2'b10) begin errors++; $display("FAIL irq_ch1_unmask: got %b expected 10", irq); end
  endtask

  task automatic test_sfrst_pulse();
    logic [31:0] d; logic v, e;
    logic [3:0] exp_tbl [8] = '{4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0};
    @(negedge aclk); write = 1'b1; addr = 16'h0048; wdata = 32'h3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge aclk); write = 1'b0;
      checks++; if (buf_sfrst !== {4'h0, exp_tbl[k-1]}) begin
        errors++; $display("FAIL sfrst_pulse_c%0d: got %h expected %h", k, buf_sfrst, {4'h0, exp_tbl[k-1]}); end
      if (k == 2) begin write = 1'b1; addr = 16'h0048; wdata = 32'h4; end
    end
    rd(16'h004C, d, v, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sfrst_sts_idle: got %h expected 00000000", d); end
  endtask

  task automatic test_sfrst_level();
    logic [31:0] d; logic v, e;
    wr(16'h0048, 32'h109);
    checks++; if (buf_sfrst !== 8'h09) begin errors++; $display("FAIL sfrst_level_on: got %h expected 09", buf_sfrst); end
    repeat (6) @(negedge aclk);
    checks++; if (buf_sfrst !== 8'h09) begin errors++; $display("FAIL sfrst_level_hold: got %h expected 09", buf_sfrst); end
    rd(16'h0048, d, v, e);
    checks++; if (d !== 32'h109) begin errors++; $display("FAIL sfrst_ctrl_rd: got %h expected 00000109", d); end
    wr(16'h0048, 32'h100);
    checks++; if (buf_sfrst !== 8'h00) begin errors++; $display("FAIL sfrst_level_off: got %h expected 00", buf_sfrst); end
    wr(16'h0048, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v, e;
    @(negedge aclk); write = 1'b1; read = 1'b1; addr = 16'h0044; wdata = 32'hF;
    @(negedge aclk); write = 1'b0; read = 1'b0;
    checks++; if ({rdatavld, rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL rd_wr_same_cycle: vld=%b data=%h expected 1 00000001", rdatavld, rdata); end
    rd(16'h0044, d, v, e);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL mask_after_rw: got %h expected 0000000f", d); end
    @(negedge aclk); read = 1'b1; addr = 16'h010C;
    @(negedge aclk); addr = 16'h0300;
    checks++; if ({rdatavld, rd_err, rdata} !== {2'b10, 32'h1234_5678}) begin
      errors++; $display("FAIL b2b_first: vld=%b err=%b data=%h expected 1 0 12345678", rdatavld, rd_err, rdata); end
    @(negedge aclk); read = 1'b0;
    checks++; if ({rdatavld, rd_err, rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL b2b_second: vld=%b err=%b data=%h expected 1 1 deadbeef", rdatavld, rd_err, rdata); end
    @(negedge aclk);
    checks++; if ({rdatavld, rd_err} !== 2'b00) begin errors++; $display("FAIL b2b_idle: vld=%b err=%b expected 0 0", rdatavld, rd_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v, e;
    wr(16'h0000, 32'h1);
    checks++; if (m_cmd[0] !== 1'b1) begin errors++; $display("FAIL go_before_reset: got %b expected 1", m_cmd[0]); end
    @(negedge aclk); write = 1'b1; addr = 16'h0048; wdata = 32'hF;
    @(negedge aclk); write = 1'b0; read = 1'b1; addr = 16'h004C;
    @(negedge aclk); read = 1'b0;
    checks++; if (rdata !== 32'h41 || buf_sfrst !== 8'h0F) begin
      errors++; $display("FAIL sfrst_sts_active: sts=%h sfrst=%h expected 00000041 0f", rdata, buf_sfrst); end
    #1 arst_n = 1'b0;
    #1;
    checks++; if ({rdatavld, rd_err, irq, buf_sfrst} !== 12'h0 || m_cmd !== 64'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset: vld=%b err=%b irq=%b sfrst=%h cmd=%h rdata=%h expected all 0", rdatavld, rd_err, irq, buf_sfrst, m_cmd, rdata); end
    @(negedge aclk); arst_n = 1'b1;
    rd(16'h004C, d, v, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sts_after_reset: got %h expected 00000000", d); end
    rd(16'h0000, d, v, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cmd_after_reset: got %h expected 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_status();
    test_sticky();
    test_sfrst_pulse();
    test_sfrst_level();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
